mix_columns_seq: RTL
====================

// Module: mix_columns_seq
// PURPOSE
//  Sequential AES MixColumns stage; consumes the 128-bit state produced by the ShiftRows stage.
//  Transforms COLS_PER_CYCLE 32-bit columns per clock, sharing GF(2^8) multiplier logic.
//  Valid/ready handshakes on both sides.
//  i_bypass passes the block through unchanged, for the final AES round, which has no MixColumns.
// PARAMETERS
//  COLS_PER_CYCLE  1  columns transformed per CALC cycle; legal values 1, 2, 4 (any other value is an elaboration error)
// PORTS
//  i_clk     in   1    clock; all state updates on the rising edge
//  i_rst_n   in   1    asynchronous, active-low reset
//  i_valid   in   1    upstream block valid
//  o_ready   out  1    stage can accept a block
//  i_block   in   128  input state (ShiftRows output); column c = i_block[127-32c -: 32], byte 0 in the MSB
//  i_bypass  in   1    sampled with i_block; 1 = output block equals input block
//  o_valid   out  1    result valid
//  i_ready   in   1    downstream accepts the result
//  o_block   out  128  result state, same column and byte layout as i_block
//  o_busy    out  1    high in CALC or DONE
// BEHAVIOUR
//  Reset (i_rst_n low, asynchronous):
//   - state=IDLE, o_valid=0, o_block=0, column counter=0, bypass flag=0.
//   - o_ready=0 while reset is held; o_ready=1 from the first cycle after release.
//  Reset mid-operation: the in-flight block is discarded with no o_valid pulse; resume in IDLE.
//  FSM states: IDLE, CALC, DONE.
//   - IDLE: o_ready=1. Accept on i_valid && o_ready at a rising edge.
//     On accept, latch i_block into the working register and latch i_bypass.
//     Then go to DONE if i_bypass=1; otherwise go to CALC with counter=0.
//   - CALC: o_ready=0. Each edge replaces columns [counter*N .. counter*N+N-1] in place (N=COLS_PER_CYCLE).
//     The counter increments each edge. After the edge that processes group 4/N-1, go to DONE.
//   - DONE: o_valid=1 and o_block=working register. Hold o_block stable while i_ready=0.
//     On i_valid-independent handshake o_valid && i_ready: go to IDLE and clear o_valid at that edge.
//  o_ready is 1 only in IDLE. A new block can be accepted no earlier than the cycle after the output handshake.
//  Latency, with acceptance at edge E0:
//   - o_valid is visible after edge E(4/N): 4 edges for N=1, 2 for N=2, 1 for N=4.
//   - Bypass: o_valid is visible after E0.
//   - Throughput with i_ready tied high: one block per 4/N+2 cycles (bypass: one per 2 cycles).
//  Column math, for input bytes a0..a3 and output bytes b0..b3:
//   - b0=2a0^3a1^a2^a3; b1=a0^2a1^3a2^a3; b2=a0^a1^2a2^3a3; b3=3a0^a1^a2^2a3.
//   - xtime(a) = {a[6:0],1'b0} ^ (a[7] ? 8'h1b : 8'h00); 3a = xtime(a)^a. All arithmetic is 8-bit XOR.
//  i_block and i_bypass are ignored outside the accept edge.
//  Changes to i_ready while o_valid=0 have no effect.
//  o_busy = (state != IDLE).
// TESTING
//  1. FIPS-197 vector, N=1:
//     i_block=db135345_f20a225c_01010101_c6c6c6c6, bypass=0 -> o_block=8e4da1bc_9fdc589d_01010101_c6c6c6c6.
//     o_valid rises 4 edges after accept.
//  2. Same vector with N=2 and N=4 -> identical o_block; o_valid after 2 edges and 1 edge respectively.
//  3. i_block=d4d4d4d5_2d26314c_00000000_ffffffff, bypass=1 -> o_block equals i_block;
//     o_valid visible after the accept edge.
//  4. Backpressure: i_ready=0 for 10 cycles in DONE -> o_valid held 1, o_block stable, o_ready=0.
//     Then i_ready=1 -> o_valid=0 next cycle and o_ready=1 in IDLE.
//  5. Back-to-back: i_valid held 1 with two blocks, i_ready=1 -> both results correct and in order.
//     Second accept occurs in the IDLE cycle after the first output handshake.
//  6. Assert i_rst_n=0 asynchronously mid-CALC -> o_valid=0, o_block=0, o_ready=0 immediately.
//     After release: o_ready=1 and no stale o_valid.

Source files
------------

// File: rtl/mix_columns_seq.sv
// mix_columns_seq: sequential AES MixColumns with valid/ready handshakes and a bypass for the final round
module mix_columns_seq #(
   parameter int COLS_PER_CYCLE = 1
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_valid,
   output logic         o_ready,
   input  logic [127:0] i_block,
   input  logic         i_bypass,
   output logic         o_valid,
   input  logic         i_ready,
   output logic [127:0] o_block,
   output logic         o_busy
);
   if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_param
      $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
   end
   localparam int G = 4 / COLS_PER_CYCLE;
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t      state;
   logic [1:0]  cnt;
   logic        byp;
   logic [31:0] w [4];
   logic [1:0]  idx [COLS_PER_CYCLE];
   logic [31:0] mixed [COLS_PER_CYCLE];
   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction
   function automatic logic [31:0] mix(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = c;
      return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
              xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
   endfunction
   // one mixer per lane, fed by whichever column the counter selects
   for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_lane
      assign idx[k]   = 2'(int'(cnt) * COLS_PER_CYCLE + k);
      assign mixed[k] = mix(w[idx[k]]);
   end
   assign o_block = {w[0], w[1], w[2], w[3]};
   assign o_busy  = state != IDLE;
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state   <= IDLE;
         o_valid <= 1'b0;
         o_ready <= 1'b0;
         cnt     <= 2'd0;
         byp     <= 1'b0;
         w       <= '{default: '0};
      end else begin
         case (state)
            IDLE: begin
               o_ready <= 1'b1;
               if (i_valid && o_ready) begin
                  for (int c = 0; c < 4; c++) w[c] <= i_block[127-32*c -: 32];
                  byp     <= i_bypass;
                  cnt     <= 2'd0;
                  o_ready <= 1'b0;
                  o_valid <= i_bypass;
                  state   <= i_bypass ? DONE : CALC;
               end
            end
            CALC: begin
               if (!byp) for (int k = 0; k < COLS_PER_CYCLE; k++) w[idx[k]] <= mixed[k];
               cnt <= cnt + 2'd1;
               if (cnt == 2'(G - 1)) begin
                  state   <= DONE;
                  o_valid <= 1'b1;
               end
            end
            DONE: begin
               if (i_ready) begin
                  state   <= IDLE;
                  o_valid <= 1'b0;
                  o_ready <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
